fault_inject_sched: RTL and testbench

- Parametrised, table-driven fault-injection scheduler for the weight-stationary BISR systolic array.
- Replaces the single hard-coded fault injector at the top level. Holds up to NUM_FAULTS programmable fault entries, each with its own target PE, fault code and timing mode (permanent, transient or intermittent).
- Drives the array's fault_inject_bus. Counters freeze on the matmul stall so injected faults stay aligned with dataflow.

---
 rtl/fault_inject_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_fault_inject_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_inject_sched.sv
// fault_inject_sched
// Table-driven fault-injection scheduler for the weight-stationary BISR
// systolic array. Up to NUM_FAULTS entries each target one PE with a 2-bit
// fault code and a permanent / transient / intermittent timing mode. All
// scheduling counters freeze while stall is high so injected faults stay
// aligned with the matmul dataflow.
module fault_inject_sched #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int NUM_FAULTS = 4,
  parameter int CNT_W      = 16,
  parameter int IDX_W      = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  parameter int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [ROW_W-1:0]         cfg_row,
  input  logic [COL_W-1:0]         cfg_col,
  input  logic [1:0]               cfg_code,
  input  logic [1:0]               cfg_mode,
  input  logic [CNT_W-1:0]         cfg_start_dly,
  input  logic [CNT_W-1:0]         cfg_dur,
  input  logic [CNT_W-1:0]         cfg_period,
  input  logic                     fi_en,
  input  logic                     stall,
  output logic [ROWS*COLS*2-1:0]   fault_inject_bus,
  output logic [NUM_FAULTS-1:0]    fi_active,
  output logic                     fi_busy,
  output logic                     fi_done,
  output logic                     cfg_err
);

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} gstate_t;
  typedef enum logic [1:0] {E_WAIT, E_ON, E_OFF, E_FIN} estate_t;

  localparam logic [1:0]       M_OFF   = 2'b00;
  localparam logic [1:0]       M_PERM  = 2'b01;
  localparam logic [1:0]       M_INTER = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               BUS_W   = ROWS * COLS * 2;

  // Fault table
  logic [1:0]       r_mode [NUM_FAULTS];
  logic [ROW_W-1:0] r_row  [NUM_FAULTS];
  logic [COL_W-1:0] r_col  [NUM_FAULTS];
  logic [1:0]       r_code [NUM_FAULTS];
  logic [CNT_W-1:0] r_dly  [NUM_FAULTS];
  logic [CNT_W-1:0] r_dur  [NUM_FAULTS];
  logic [CNT_W-1:0] r_per  [NUM_FAULTS];

  gstate_t           r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_err, w_err_next;
  logic [BUS_W-1:0]  r_bus, w_bus_next;

  logic              w_row_ok, w_col_ok, w_int_bad, w_wr_ok, w_run_hold, w_all_fin;
  logic [CNT_W-1:0]  w_cfg_dur_eff;
  logic [1:0]        w_wr_mode;
  logic [NUM_FAULTS-1:0] w_en_after, w_on_next, w_fin_ok;

  // Write decode: out-of-range targets are dropped; an intermittent entry
  // whose period cannot fit an OFF phase degrades to permanent.
  assign w_row_ok      = ({1'b0, cfg_row} < (ROW_W+1)'(ROWS));
  assign w_col_ok      = ({1'b0, cfg_col} < (COL_W+1)'(COLS));
  assign w_cfg_dur_eff = (cfg_dur == '0) ? CNT_W'(1) : cfg_dur;
  assign w_int_bad     = (cfg_mode == M_INTER) && (cfg_period <= w_cfg_dur_eff);
  assign w_wr_ok       = cfg_wr_en && (r_state == G_IDLE) && w_row_ok && w_col_ok;
  assign w_wr_mode     = w_int_bad ? M_PERM : cfg_mode;
  assign w_run_hold    = (r_state == G_RUN) && (w_state_next == G_RUN);
  assign w_all_fin     = &w_fin_ok;

  // Table storage, only writable while idle; lost on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NUM_FAULTS; e++) begin
        r_mode[e] <= M_OFF;
        r_row[e]  <= '0;
        r_col[e]  <= '0;
        r_code[e] <= '0;
        r_dly[e]  <= '0;
        r_dur[e]  <= '0;
        r_per[e]  <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_FAULTS; e++) begin
        if (w_wr_ok && (cfg_idx == IDX_W'(e))) begin
          r_mode[e] <= w_wr_mode;
          r_row[e]  <= cfg_row;
          r_col[e]  <= cfg_col;
          r_code[e] <= cfg_code;
          r_dly[e]  <= cfg_start_dly;
          r_dur[e]  <= cfg_dur;
          r_per[e]  <= cfg_period;
        end
      end
    end
  end

  // Per-entry timing FSMs
  for (genvar gi = 0; gi < NUM_FAULTS; gi++) begin : g_entry
    estate_t          r_est, w_est_next;
    logic [CNT_W-1:0] r_ecnt, w_ecnt_next;
    logic [CNT_W:0]   w_ecnt_inc;
    logic [CNT_W-1:0] w_dur_eff, w_off_len;
    logic             w_sel;

    assign w_sel      = w_wr_ok && (cfg_idx == IDX_W'(gi));
    assign w_en_after[gi] = w_sel ? (w_wr_mode != M_OFF) : (r_mode[gi] != M_OFF);
    assign w_dur_eff  = (r_dur[gi] == '0) ? CNT_W'(1) : r_dur[gi];
    assign w_off_len  = r_per[gi] - w_dur_eff;

    // Next entry state: restart in WAIT outside a running schedule, hold on stall
    always_comb begin
      w_est_next  = r_est;
      w_ecnt_next = r_ecnt;
      w_ecnt_inc  = {1'b0, r_ecnt} + 1'b1;
      if (!w_run_hold) begin
        w_est_next  = E_WAIT;
        w_ecnt_next = '0;
      end else if (!stall) begin
        case (r_est)
          E_WAIT: begin
            if ((r_mode[gi] != M_OFF) && (r_cnt == r_dly[gi])) begin
              w_est_next  = E_ON;
              w_ecnt_next = '0;
            end
          end
          E_ON: begin
            if (r_mode[gi] != M_PERM) begin
              if (w_ecnt_inc >= {1'b0, w_dur_eff}) begin
                w_ecnt_next = '0;
                w_est_next  = (r_mode[gi] == M_INTER) ? E_OFF : E_FIN;
              end else begin
                w_ecnt_next = w_ecnt_inc[CNT_W-1:0];
              end
            end
          end
          E_OFF: begin
            if (w_ecnt_inc >= {1'b0, w_off_len}) begin
              w_ecnt_next = '0;
              w_est_next  = E_ON;
            end else begin
              w_ecnt_next = w_ecnt_inc[CNT_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end

    // Entry state register
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_est  <= E_WAIT;
        r_ecnt <= '0;
      end else begin
        r_est  <= w_est_next;
        r_ecnt <= w_ecnt_next;
      end
    end

    assign w_on_next[gi] = (w_est_next == E_ON);
    assign w_fin_ok[gi]  = (r_mode[gi] == M_OFF) || (r_est == E_FIN);
    assign fi_active[gi] = (r_est == E_ON);
  end

  // Global next state and error pulse
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    case (r_state)
      G_IDLE: begin
        if (cfg_wr_en && (!w_row_ok || !w_col_ok || w_int_bad)) w_err_next = 1'b1;
        if (fi_en) begin
          if (|w_en_after) w_state_next = G_RUN;
          else             w_err_next   = 1'b1;
        end
      end
      G_RUN: begin
        if (cfg_wr_en) w_err_next = 1'b1;
        if (!fi_en)         w_state_next = G_IDLE;
        else if (w_all_fin) w_state_next = G_DONE;
      end
      G_DONE: begin
        if (cfg_wr_en) w_err_next = 1'b1;
        if (!fi_en) w_state_next = G_IDLE;
      end
      default: w_state_next = G_IDLE;
    endcase
  end

  // Run-time cycle counter: saturating, frozen by stall, held in DONE
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_run_hold) begin
      if (!stall && (r_cnt != CNT_MAX)) w_cnt_next = r_cnt + 1'b1;
    end else if (w_state_next != G_DONE) begin
      w_cnt_next = '0;
    end
  end

  // Bus slice per PE: OR of codes of every entry that will be ON
  for (genvar gi = 0; gi < ROWS * COLS; gi++) begin : g_pe
    localparam int PR = gi % ROWS;
    localparam int PC = gi / ROWS;
    logic [1:0] w_slice;

    // Collect codes of entries targeting this PE
    always_comb begin
      w_slice = 2'b00;
      for (int e = 0; e < NUM_FAULTS; e++) begin
        if (w_on_next[e] && (r_row[e] == ROW_W'(PR)) && (r_col[e] == COL_W'(PC)))
          w_slice = w_slice | r_code[e];
      end
    end

    assign w_bus_next[gi*2 +: 2] = w_slice;
  end

  // Global state, counter, bus and error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= G_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_bus   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_bus   <= w_bus_next;
    end
  end

  assign fault_inject_bus = r_bus;
  assign fi_busy          = (r_state == G_RUN);
  assign fi_done          = (r_state == G_DONE);
  assign cfg_err          = r_err;

endmodule

// File: tb/tb_fault_inject_sched.sv
// Scoreboard bench for fault_inject_sched: each driven cycle pushes the
// reference model's expected outputs; a monitor pops and compares them.
module tb_fault_inject_sched;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NF    = 4;
  localparam int CNT_W = 16;
  localparam int BW    = ROWS * COLS * 2;
  localparam int EW    = BW + NF + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_wr_en = 1'b0;
  logic [1:0]       cfg_idx = '0, cfg_row = '0, cfg_col = '0, cfg_code = '0, cfg_mode = '0;
  logic [CNT_W-1:0] cfg_start_dly = '0, cfg_dur = '0, cfg_period = '0;
  logic             fi_en = 1'b0, stall = 1'b0;
  logic [BW-1:0]    fault_inject_bus;
  logic [NF-1:0]    fi_active;
  logic             fi_busy, fi_done, cfg_err;

  fault_inject_sched dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_code(cfg_code), .cfg_mode(cfg_mode),
    .cfg_start_dly(cfg_start_dly), .cfg_dur(cfg_dur), .cfg_period(cfg_period),
    .fi_en(fi_en), .stall(stall), .fault_inject_bus(fault_inject_bus),
    .fi_active(fi_active), .fi_busy(fi_busy), .fi_done(fi_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // stimulus staged for the next driven cycle
  logic n_rst = 1'b0;
  int   n_idx, n_row, n_col, n_code, n_mode, n_dly, n_dur, n_per;

  // reference model: table plus run-time cycle count
  int         t_mode[NF], t_row[NF], t_col[NF], t_dly[NF], t_dur[NF], t_per[NF];
  logic [1:0] t_code[NF];
  int         m_st;   // 0 idle, 1 run, 2 done
  int         m_c;    // non-stalled run cycles elapsed
  logic [BW-1:0] m_bus;
  logic [NF-1:0] m_act;
  logic          m_err;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [EW-1:0] exp_vec();
    return {m_bus, m_act, (m_st == 1), (m_st == 2), m_err};
  endfunction

  task automatic model_reset();
    for (int e = 0; e < NF; e++) begin
      t_mode[e] = 0; t_row[e] = 0; t_col[e] = 0; t_dly[e] = 0;
      t_dur[e] = 0; t_per[e] = 0; t_code[e] = 2'b00;
    end
    m_st = 0; m_c = 0; m_bus = '0; m_act = '0; m_err = 1'b0;
  endtask

  // An entry is ON after the edge at which c non-stalled cycles had elapsed
  // when c lies in its activation window.
  task automatic model_step();
    int  de;
    bit  any, alldone, on;
    logic [BW-1:0] nb;
    logic [NF-1:0] na;
    m_err = 1'b0;
    if (m_st == 0) begin
      if (cfg_wr_en) begin
        de = (cfg_dur == 0) ? 1 : int'(cfg_dur);
        if (int'(cfg_row) >= ROWS || int'(cfg_col) >= COLS) m_err = 1'b1;
        else begin
          t_mode[cfg_idx] = int'(cfg_mode);
          t_row[cfg_idx]  = int'(cfg_row);
          t_col[cfg_idx]  = int'(cfg_col);
          t_code[cfg_idx] = cfg_code;
          t_dly[cfg_idx]  = int'(cfg_start_dly);
          t_dur[cfg_idx]  = int'(cfg_dur);
          t_per[cfg_idx]  = int'(cfg_period);
          if (cfg_mode == 2'b11 && int'(cfg_period) <= de) begin
            t_mode[cfg_idx] = 1;
            m_err = 1'b1;
          end
        end
      end
      if (fi_en) begin
        any = 0;
        for (int e = 0; e < NF; e++) if (t_mode[e] != 0) any = 1;
        if (any) begin m_st = 1; m_c = 0; end
        else m_err = 1'b1;
      end
      m_bus = '0; m_act = '0;
    end else begin
      if (cfg_wr_en) m_err = 1'b1;
      if (!fi_en) begin
        m_st = 0; m_bus = '0; m_act = '0;
      end else if (m_st == 1) begin
        alldone = 1;
        for (int e = 0; e < NF; e++) begin
          de = (t_dur[e] == 0) ? 1 : t_dur[e];
          if (t_mode[e] != 0 && !(t_mode[e] == 2 && m_c >= t_dly[e] + de + 1)) alldone = 0;
        end
        if (alldone) begin
          m_st = 2; m_bus = '0; m_act = '0;
        end else if (!stall) begin
          nb = '0; na = '0;
          for (int e = 0; e < NF; e++) begin
            de = (t_dur[e] == 0) ? 1 : t_dur[e];
            on = 0;
            if (t_mode[e] != 0 && m_c >= t_dly[e]) begin
              case (t_mode[e])
                1: on = 1;
                2: on = (m_c < t_dly[e] + de);
                3: on = (((m_c - t_dly[e]) % t_per[e]) < de);
                default: on = 0;
              endcase
            end
            if (on) begin
              na[e] = 1'b1;
              nb[(t_col[e] * ROWS + t_row[e]) * 2 +: 2] = nb[(t_col[e] * ROWS + t_row[e]) * 2 +: 2] | t_code[e];
            end
          end
          m_bus = nb; m_act = na;
          if (m_c < 65535) m_c = m_c + 1;
        end
      end
    end
  endtask

  // one driven cycle: inputs change just after the falling edge
  task automatic cyc(input logic wr, input logic en, input logic st);
    @(negedge clk); #1;
    rst = n_rst; cfg_wr_en = wr; fi_en = en; stall = st;
    cfg_idx = 2'(n_idx); cfg_row = 2'(n_row); cfg_col = 2'(n_col);
    cfg_code = 2'(n_code); cfg_mode = 2'(n_mode);
    cfg_start_dly = 16'(n_dly); cfg_dur = 16'(n_dur); cfg_period = 16'(n_per);
    if (!n_rst) model_reset();
    else        model_step();
    exp_q.push_back(exp_vec());
  endtask

  task automatic prog(input int idx, input int row, input int col, input int code,
                      input int mode, input int dly, input int dur, input int per,
                      input logic en);
    n_idx = idx; n_row = row; n_col = col; n_code = code;
    n_mode = mode; n_dly = dly; n_dur = dur; n_per = per;
    $display("prog idx=%0d row=%0d col=%0d code=%0d mode=%0d dly=%0d dur=%0d per=%0d en=%0b",
             idx, row, col, code, mode, dly, dur, per, en);
    cyc(1'b1, en, 1'b0);
  endtask

  task automatic run(input int n);
    $display("run %0d cycles", n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // asynchronous reset mid-cycle: outputs must clear before the next edge
  task automatic async_rst_check();
    @(negedge clk); #1;
    n_rst = 1'b0; rst = 1'b0;
    #1;
    n_cmp++;
    if ({fault_inject_bus, fi_active, fi_busy, fi_done} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got bus=%h act=%b busy=%b done=%b required all zero",
               fault_inject_bus, fi_active, fi_busy, fi_done);
    end
    $display("async reset asserted mid-cycle");
    model_reset();
    exp_q.push_back(exp_vec());
  endtask

  // monitor: compares every cycle against the scoreboard
  logic [EW-1:0] mon_exp, mon_got;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = {fault_inject_bus, fi_active, fi_busy, fi_done, cfg_err};
        n_cmp++;
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL out_check t=%0t got bus=%h act=%b busy=%b done=%b err=%b required bus=%h act=%b busy=%b done=%b err=%b",
                   $time, mon_got[EW-1 -: BW], mon_got[NF+2 : 3], mon_got[2], mon_got[1], mon_got[0],
                   mon_exp[EW-1 -: BW], mon_exp[NF+2 : 3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  initial begin
    int nw, len, idx, md;
    logic en;
    n_idx = 0; n_row = 0; n_col = 0; n_code = 0; n_mode = 0; n_dly = 0; n_dur = 0; n_per = 0;
    model_reset();
    n_rst = 1'b0;
    idle(3);
    n_rst = 1'b1;
    idle(2);

    // transient single entry
    $display("scenario transient row1 col2");
    prog(0, 1, 2, 3, 2, 3, 2, 0, 1'b0);
    run(12); idle(2);

    // intermittent pattern
    $display("scenario intermittent row0 col0");
    prog(0, 0, 0, 1, 3, 0, 2, 5, 1'b0);
    run(20); idle(2);

    // overlapping entries on one PE
    $display("scenario overlap on PE(2,3)");
    prog(0, 2, 3, 1, 2, 1, 4, 0, 1'b0);
    prog(1, 2, 3, 2, 2, 3, 4, 0, 1'b0);
    run(15); idle(2);

    // stall inside the active window
    $display("scenario stall during burst");
    prog(0, 3, 1, 2, 2, 2, 3, 0, 1'b0);
    prog(1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    run(4);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1);
    run(8); idle(2);

    // write attempted during RUN, then degraded intermittent entry
    $display("scenario config errors");
    prog(0, 1, 1, 1, 2, 5, 2, 0, 1'b0);
    run(2);
    n_idx = 0; n_row = 3; n_col = 3; n_code = 3; n_mode = 1; n_dly = 0; n_dur = 1; n_per = 0;
    cyc(1'b1, 1'b1, 1'b0);
    run(8); idle(2);
    prog(0, 2, 2, 3, 3, 1, 3, 2, 1'b0);
    run(6);
    async_rst_check();
    n_rst = 1'b1;
    run(2); idle(2);

    // randomized schedules
    for (int r = 0; r < 30; r++) begin
      nw = 1 + int'($urandom % 4);
      for (int w = 0; w < nw; w++) begin
        idx = int'($urandom % NF);
        md  = int'($urandom % 4);
        en  = (w == nw - 1) && ($urandom % 2 == 0);
        prog(idx, int'($urandom % ROWS), int'($urandom % COLS), int'($urandom % 4), md,
             int'($urandom % 9), int'($urandom % 5), int'($urandom % 11), en);
      end
      len = 5 + int'($urandom % 35);
      $display("random run %0d: %0d cycles", r, len);
      for (int k = 0; k < len; k++)
        cyc(($urandom % 15) == 0, 1'b1, ($urandom % 5) == 0);
      idle(2);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
